// File: rtl/gshare_predictor.sv
// ---------------------------------------------------------------------------
// gshare_predictor
//   Global-history (gshare) conditional branch predictor. The fetch PC is
//   XOR-ed with a speculative global history register (GHR) to index a table
//   of saturating counters (PHT). The execute stage returns the resolved
//   outcome together with the index and GHR snapshot captured at lookup; it
//   trains the counter and, on a mispredict, repairs the GHR.
//
//   After reset the table is filled with weakly-not-taken counters, one entry
//   per cycle. While that runs, `ready` is low, predictions are not-taken and
//   resolves are ignored.
//
//   Optional feature macro: PREDICTOR_STATS_EN
//     defined   -> saturating resolved-branch / mispredict counters
//     undefined -> statBranches / statMispredicts tied to 0, no flops
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   ready               table initialisation complete
//   lookupValid/Pc      fetch-stage query
//   predictTaken        combinational prediction for lookupPc
//   predictIndex/Ghr    PHT index and GHR used by this lookup
//   resolveValid        execute-stage resolve strobe
//   resolveTaken        actual outcome
//   resolveMispredict   predicted direction differed from outcome
//   resolveIndex/Ghr    snapshot carried down the pipe from the lookup
//   statBranches        resolved-branch count
//   statMispredicts     mispredict count
// ---------------------------------------------------------------------------
module gshare_predictor #(
  parameter int PC_WIDTH    = 32,
  parameter int PHT_ENTRIES = 256,
  parameter int GHR_WIDTH   = 8,
  parameter int CTR_WIDTH   = 2,
  localparam int IDX_W      = $clog2(PHT_ENTRIES)
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 ready,
  input  logic                 lookupValid,
  input  logic [PC_WIDTH-1:0]  lookupPc,
  output logic                 predictTaken,
  output logic [IDX_W-1:0]     predictIndex,
  output logic [GHR_WIDTH-1:0] predictGhr,
  input  logic                 resolveValid,
  input  logic                 resolveTaken,
  input  logic                 resolveMispredict,
  input  logic [IDX_W-1:0]     resolveIndex,
  input  logic [GHR_WIDTH-1:0] resolveGhr,
  output logic [31:0]          statBranches,
  output logic [31:0]          statMispredicts
);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  localparam logic [CTR_WIDTH-1:0] CTR_WNT  = {1'b0, {(CTR_WIDTH-1){1'b1}}};
  localparam logic [CTR_WIDTH-1:0] CTR_MAX  = '1;
  localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(PHT_ENTRIES - 1);

  state_e                 state_q, state_d;
  logic                   ready_q, ready_d;
  logic [IDX_W-1:0]       init_ptr_q, init_ptr_d;
  logic [GHR_WIDTH-1:0]   ghr_q, ghr_d;

  logic [CTR_WIDTH-1:0]   pht_q [PHT_ENTRIES];
  logic                   pht_we;
  logic [IDX_W-1:0]       pht_waddr;
  logic [CTR_WIDTH-1:0]   pht_wdata;

  logic [IDX_W-1:0]       lookup_idx;
  logic [CTR_WIDTH-1:0]   lookup_ctr;
  logic [CTR_WIDTH-1:0]   resolve_ctr;
  logic [CTR_WIDTH-1:0]   resolve_ctr_next;
  logic                   run;
  logic                   unused_pc_bits;

  // Only the word-aligned bits that form the index matter.
  assign unused_pc_bits = ^{lookupPc[PC_WIDTH-1:IDX_W+2], lookupPc[1:0]};

  // Shift a new outcome into the bottom of a history value. Taking the low
  // GHR_WIDTH bits of the concatenation also covers GHR_WIDTH == 1, where
  // the result is just the new bit.
  function automatic logic [GHR_WIDTH-1:0] hist_shift(
    input logic [GHR_WIDTH-1:0] hist,
    input logic                 new_bit
  );
    return GHR_WIDTH'({hist, new_bit});
  endfunction

  assign run          = (state_q == ST_RUN);
  assign lookup_idx   = lookupPc[IDX_W+1:2] ^ IDX_W'(ghr_q);
  assign lookup_ctr   = pht_q[lookup_idx];
  assign predictTaken = run & lookup_ctr[CTR_WIDTH-1];
  assign predictIndex = lookup_idx;
  assign predictGhr   = ghr_q;
  assign ready        = ready_q;

  // Saturating train of the resolved entry; reads the pre-edge value, so a
  // same-cycle lookup of that entry sees the old counter.
  assign resolve_ctr = pht_q[resolveIndex];
  always_comb begin
    resolve_ctr_next = resolve_ctr;
    if (resolveTaken) begin
      if (resolve_ctr != CTR_MAX) resolve_ctr_next = resolve_ctr + 1'b1;
    end else begin
      if (resolve_ctr != '0) resolve_ctr_next = resolve_ctr - 1'b1;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a value unassigned and no latch is inferred.
    state_d    = state_q;
    ready_d    = ready_q;
    init_ptr_d = init_ptr_q;
    ghr_d      = ghr_q;
    pht_we     = 1'b0;
    pht_waddr  = resolveIndex;
    pht_wdata  = resolve_ctr_next;
    unique case (state_q)
      ST_INIT: begin
        pht_we     = 1'b1;
        pht_waddr  = init_ptr_q;
        pht_wdata  = CTR_WNT;
        init_ptr_d = init_ptr_q + 1'b1;
        if (init_ptr_q == IDX_LAST) begin
          state_d = ST_RUN;
          ready_d = 1'b1;
        end
      end
      ST_RUN: begin
        pht_we = resolveValid;
        // Repair wins over the speculative shift from a same-cycle lookup.
        if (resolveValid && resolveMispredict) begin
          ghr_d = hist_shift(resolveGhr, resolveTaken);
        end else if (lookupValid) begin
          ghr_d = hist_shift(ghr_q, predictTaken);
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_INIT;
      ready_q    <= 1'b0;
      init_ptr_q <= '0;
      ghr_q      <= '0;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      init_ptr_q <= init_ptr_d;
      ghr_q      <= ghr_d;
    end
  end

  // NOTE: the counter table has no reset; it is filled by the INIT sweep,
  // which keeps it mappable onto plain RAM.
  always_ff @(posedge clk) begin
    if (pht_we) pht_q[pht_waddr] <= pht_wdata;
  end

`ifdef PREDICTOR_STATS_EN
  logic [31:0] stat_br_q, stat_br_d;
  logic [31:0] stat_mp_q, stat_mp_d;

  always_comb begin
    stat_br_d = stat_br_q;
    stat_mp_d = stat_mp_q;
    if (run && resolveValid) begin
      if (stat_br_q != '1) stat_br_d = stat_br_q + 32'd1;
      if (resolveMispredict && (stat_mp_q != '1)) stat_mp_d = stat_mp_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      stat_br_q <= stat_br_d;
      stat_mp_q <= stat_mp_d;
    end
  end

  assign statBranches    = stat_br_q;
  assign statMispredicts = stat_mp_q;
`else
  assign statBranches    = 32'd0;
  assign statMispredicts = 32'd0;
`endif

endmodule

// File: tb/tb_gshare_predictor.sv
// ---------------------------------------------------------------------------
// tb_gshare_predictor
//   Drives gshare_predictor with directed and random traffic. A behavioural
//   model (plain integer table + integer history) predicts every output; a
//   compare process checks the DUT against it each cycle, and directed steps
//   pin the model with hand-computed literals.
// ---------------------------------------------------------------------------
module tb_gshare_predictor;

  localparam int PCW   = 32;
  localparam int N     = 256;
  localparam int IDX_W = 8;
  localparam int G     = 8;
  localparam int C     = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             ready;
  logic             lookupValid = 1'b0;
  logic [PCW-1:0]   lookupPc = '0;
  logic             predictTaken;
  logic [IDX_W-1:0] predictIndex;
  logic [G-1:0]     predictGhr;
  logic             resolveValid = 1'b0;
  logic             resolveTaken = 1'b0;
  logic             resolveMispredict = 1'b0;
  logic [IDX_W-1:0] resolveIndex = '0;
  logic [G-1:0]     resolveGhr = '0;
  logic [31:0]      statBranches;
  logic [31:0]      statMispredicts;

  int total = 0;
  int bad   = 0;

  gshare_predictor #(
    .PC_WIDTH(PCW), .PHT_ENTRIES(N), .GHR_WIDTH(G), .CTR_WIDTH(C)
  ) dut (
    .clk(clk), .rst(rst), .ready(ready),
    .lookupValid(lookupValid), .lookupPc(lookupPc),
    .predictTaken(predictTaken), .predictIndex(predictIndex),
    .predictGhr(predictGhr),
    .resolveValid(resolveValid), .resolveTaken(resolveTaken),
    .resolveMispredict(resolveMispredict), .resolveIndex(resolveIndex),
    .resolveGhr(resolveGhr),
    .statBranches(statBranches), .statMispredicts(statMispredicts)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int     m_pht [N];
  int     m_ghr;
  int     m_init;
  bit     m_ready;
  longint m_br, m_mp;

  function automatic int m_index(input logic [PCW-1:0] pc);
    return ((int'(pc) >> 2) & (N - 1)) ^ m_ghr;
  endfunction

  function automatic bit m_pred(input logic [PCW-1:0] pc);
    return m_pht[m_index(pc)] >= (1 << (C - 1));
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_init = 0; m_ready = 0; m_ghr = 0; m_br = 0; m_mp = 0;
    end else if (!m_ready) begin
      m_init++;
      if (m_init == N) begin
        m_ready = 1;
        for (int i = 0; i < N; i++) m_pht[i] = (1 << (C - 1)) - 1;
      end
    end else begin
      bit p;
      p = m_pred(lookupPc);
      if (resolveValid) begin
        int k;
        k = int'(resolveIndex);
        if (resolveTaken) m_pht[k] = (m_pht[k] == (1 << C) - 1) ? m_pht[k] : m_pht[k] + 1;
        else              m_pht[k] = (m_pht[k] == 0) ? 0 : m_pht[k] - 1;
        if (m_br < 64'hFFFF_FFFF) m_br++;
        if (resolveMispredict && m_mp < 64'hFFFF_FFFF) m_mp++;
      end
      if (resolveValid && resolveMispredict)
        m_ghr = ((int'(resolveGhr) << 1) | int'(resolveTaken)) & ((1 << G) - 1);
      else if (lookupValid)
        m_ghr = ((m_ghr << 1) | int'(p)) & ((1 << G) - 1);
    end
  end

  // ---------------- per-cycle compare ----------------
  always begin
    @(negedge clk);
    #2;
    if (rst) begin
      check("ready", ready, m_ready);
      if (!m_ready) begin
        check("init_pred", predictTaken, 0);
      end else if (lookupValid) begin
        check("pred_idx", predictIndex, m_index(lookupPc));
        check("pred_ghr", predictGhr, m_ghr);
        check("pred_taken", predictTaken, m_pred(lookupPc));
      end
`ifdef PREDICTOR_STATS_EN
      check("stat_br", statBranches, m_br);
      check("stat_mp", statMispredicts, m_mp);
`else
      check("stat_br_off", statBranches, 0);
      check("stat_mp_off", statMispredicts, 0);
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input bit lv, input int pc, input bit rv, input bit rt,
                       input bit rm, input int ridx, input int rghr);
    @(negedge clk);
    lookupValid       = lv;
    lookupPc          = PCW'(pc);
    resolveValid      = rv;
    resolveTaken      = rt;
    resolveMispredict = rm;
    resolveIndex      = IDX_W'(ridx);
    resolveGhr        = G'(rghr);
    #1;
  endtask

  task automatic drive_random();
    drive($urandom_range(0, 1) == 1, int'($urandom),
          $urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1,
          $urandom_range(0, 3) == 0, int'($urandom), int'($urandom));
  endtask

  // Release reset and count edges until ready rises (bounded).
  task automatic release_and_wait();
    int n;
    n = 0;
    @(negedge clk);
    rst = 1'b1;
    do begin
      @(posedge clk);
      n++;
      #1;
    end while (!ready && n < 1000);
    check("init_cycles", n, N);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    // Junk on the inputs during INIT must be ignored.
    lookupValid = 1'b1; lookupPc = 32'h104;
    resolveValid = 1'b1; resolveTaken = 1'b1; resolveMispredict = 1'b1;
    resolveIndex = 8'h40; resolveGhr = 8'hFF;
    repeat (3) @(negedge clk);
    release_and_wait();

    // Fresh table: PC 0x100 -> index 0x40, not-taken, GHR 0.
    drive(1, 'h100, 0, 0, 0, 0, 0);
    check("t1_taken", predictTaken, 0);
    check("t1_ghr", predictGhr, 0);
    check("t1_idx", predictIndex, 8'h40);

    // Three taken resolves saturate counter 0x40; lookup then predicts taken.
    repeat (3) drive(0, 0, 1, 1, 0, 'h40, 0);
    drive(1, 'h100, 0, 0, 0, 0, 0);
    check("t2_taken", predictTaken, 1);

    // Repair GHR to 0x03 while training 0x42 to weakly-taken.
    drive(0, 0, 1, 1, 1, 'h42, 'h01);
    drive(1, 'h104, 0, 0, 0, 0, 0);
    check("t3_ghr", predictGhr, 8'h03);
    check("t3_idx", predictIndex, 8'h42);
    check("t3_taken", predictTaken, 1);
    drive(1, 'h104, 0, 0, 0, 0, 0);
    check("t3_shift", predictGhr, 8'h07);

    // Lookup and mispredict repair in the same cycle: repair wins.
    drive(1, 'h104, 1, 0, 1, 'h20, 'hA5);
    // PC 0x168 with GHR 0x4A -> index 0x10; same-cycle train sees old value.
    drive(1, 'h168, 1, 1, 0, 'h10, 0);
    check("t4_repair", predictGhr, 8'h4A);
    check("t5_idx", predictIndex, 8'h10);
    check("t5_old", predictTaken, 0);
    // GHR now 0x94; PC 0x210 -> index 0x10 again, counter is weakly-taken.
    drive(1, 'h210, 0, 0, 0, 0, 0);
    check("t5_idx2", predictIndex, 8'h10);
    check("t5_new", predictTaken, 1);

    // Random traffic with a reset in the middle.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        do_reset();
        release_and_wait();
      end
      drive_random();
    end

`ifdef PREDICTOR_STATS_EN
    drive(0, 0, 0, 0, 0, 0, 0);
    do_reset();
    release_and_wait();
    check("t6_br0", statBranches, 0);
    drive(0, 0, 1, 1, 1, 1, 0);
    drive(0, 0, 1, 0, 0, 2, 0);
    drive(0, 0, 1, 1, 1, 3, 0);
    drive(0, 0, 1, 0, 0, 4, 0);
    drive(0, 0, 1, 1, 0, 5, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    check("t6_br5", statBranches, 5);
    check("t6_mp2", statMispredicts, 2);
    drive(0, 0, 1, 1, 1, 6, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t6_rst_br", statBranches, 0);
    check("t6_rst_mp", statMispredicts, 0);
    // Resolves held active through INIT must not be counted.
    release_and_wait();
    check("t6_init_br", statBranches, 0);
    check("t6_init_mp", statMispredicts, 0);
`endif

    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/gshare_predictor.md
Name: gshare_predictor

Overview:
Parametrised global-history (gshare) conditional branch predictor. It replaces the fixed single-bit taken/not-taken handshake between the execute stage and the branch predictor.
- Fetch stage queries it with the fetch PC.
- Execute stage returns the resolved outcome, carrying the index and history snapshot taken at lookup.
- Keeps a speculative global history register (GHR), repairs it on mispredict, and trains a table of saturating counters (PHT).

Parameters:
PC_WIDTH, 32, width of fetch/execute PC.
PHT_ENTRIES, 256, number of counters; power of two, ≥4.
GHR_WIDTH, 8, global history bits; 1 ≤ GHR_WIDTH ≤ log2(PHT_ENTRIES).
CTR_WIDTH, 2, saturating counter width; ≥2.

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
ready  out  1  high once table initialisation is complete
lookupValid  in  1  fetch has a BTB-hit branch this cycle
lookupPc  in  PC_WIDTH  fetch PC
predictTaken  out  1  prediction for lookupPc (combinational)
predictIndex  out  IDX_W  PHT index used (IDX_W = log2(PHT_ENTRIES))
predictGhr  out  GHR_WIDTH  GHR value used for this lookup
resolveValid  in  1  execute stage resolves a conditional branch
resolveTaken  in  1  actual outcome
resolveMispredict  in  1  predicted direction differed from outcome
resolveIndex  in  IDX_W  predictIndex carried down the pipe
resolveGhr  in  GHR_WIDTH  predictGhr carried down the pipe
statBranches  out  32  resolved-branch count (optional feature)
statMispredicts  out  32  mispredict count (optional feature)

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to INIT; init pointer = 0; GHR = 0; ready = 0.
  - Stats = 0. PHT contents are not reset directly.
- INIT state:
  - Writes weakly-not-taken (value 2^(CTR_WIDTH-1)-1, i.e. 01 for 2 bits) to one entry per cycle at the init pointer, then increments the pointer.
  - After entry PHT_ENTRIES-1 is written, moves to RUN; ready = 1 on the next cycle.
  - Init therefore takes exactly PHT_ENTRIES cycles after reset release.
  - During INIT: predictTaken = 0, lookups do not shift the GHR, resolves are ignored (no training, no stats).
- RUN state, lookup:
  - Index = lookupPc[IDX_W+1:2] XOR zero-extended GHR.
  - predictTaken = MSB of PHT[index].
  - predictIndex and predictGhr are combinational from the current state; valid only when lookupValid=1.
- Speculative history: on lookupValid=1 (and no mispredict that cycle), GHR <= {GHR[GHR_WIDTH-2:0], predictTaken} at the clock edge.
- Resolve:
  - On resolveValid=1, PHT[resolveIndex] is incremented if taken, else decremented.
  - The counter saturates at all-ones and zero; no wrap.
- Mispredict repair: when resolveValid & resolveMispredict, GHR <= {resolveGhr[GHR_WIDTH-2:0], resolveTaken}.
  - Repair overrides any same-cycle lookup shift.
  - The same-cycle lookup still returns a prediction computed from the pre-repair GHR.
- Read/write collision: a lookup and a resolve to the same index in the same cycle return the old counter. There is no bypass; the write lands at the edge.
- resolveMispredict with resolveValid=0 is ignored.
- GHR_WIDTH=1: the shift reduces to GHR <= new bit.
- Reset asserted mid-operation: everything restarts in INIT; in-flight resolves are lost.

Optional Feature:
Macro PREDICTOR_STATS_EN.
- Defined:
  - statBranches increments on every resolveValid in RUN.
  - statMispredicts increments on resolveValid & resolveMispredict in RUN.
  - Both saturate at 32'hFFFF_FFFF.
- Undefined: both ports are tied to 0 and no counter flops are generated.

Test Plan:
1. Reset release with PHT_ENTRIES=256 -> ready=0 for exactly 256 cycles, then 1. Lookup at PC 0x100 predicts not-taken; predictGhr=0.
2. With ready=1, GHR=0: three resolves taken at index 0x40 -> counter 01→10→11→11 (saturates). Lookup at PC 0x100 (index 0x40) then gives predictTaken=1.
3. GHR=8'b0000_0011 and lookupPc=0x104 -> predictIndex = 0x41 XOR 0x03 = 0x42. After a lookupValid predicting taken, GHR=8'b0000_0111.
4. Same-cycle lookup plus mispredict resolve (resolveGhr=8'hA5, resolveTaken=0) -> next GHR=8'h4A, not the lookup-shifted value.
5. Same-cycle lookup and resolve-taken to index 0x10 holding 01 -> predictTaken=0 that cycle; the next lookup to 0x10 gives 1.
6. With PREDICTOR_STATS_EN: 5 resolves, 2 mispredicts -> statBranches=5, statMispredicts=2. Assert rst mid-count -> both 0; resolves during INIT are not counted.
